// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, data width and the
// bit-period helper shared by the receiver and the future transmitter.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    // Integer floor of clocks per serial bit.
    function automatic int clks_per_bit(
        input int clock_freq,
        input int baud_rate
    );
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// Ports: clk, rst (sync, active-high), d (async in), q (synchronized out).
module uart_rx_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a single-entry valid/ready output buffer.
// Ports: clk, rst (sync, active-high), urx_pin (serial in, idles high),
//   urx_valid/urx_data/urx_ready (byte handshake),
//   urx_frame_err, urx_overrun (1-cycle error pulses).
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 urx_pin,
    output logic                 urx_valid,
    output logic [DATA_BITS-1:0] urx_data,
    input  logic                 urx_ready,
    output logic                 urx_frame_err,
    output logic                 urx_overrun
);

    localparam int CPB  = clks_per_bit(CLOCK_FREQ, BAUD_RATE);
    localparam int HALF = CPB / 2;
    localparam int CW   = $clog2(CPB);
    localparam int BW   = $clog2(DATA_BITS);

    localparam logic [CW-1:0] CNT_LAST  = CW'(CPB - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    logic                 rx_s;
    rx_state_t            state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [BW-1:0]        bit_idx, bit_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 deliver;
    logic                 ferr_set;

    uart_rx_sync #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (urx_pin),
        .q  (rx_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_n;
            shreg   <= shreg_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        bit_n    = bit_idx;
        shreg_n  = shreg;
        deliver  = 1'b0;
        ferr_set = 1'b0;
        unique case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_n = START;
                    cnt_n   = '0;
                end
            end
            START: begin
                // Sample mid start bit; a high line here was a glitch.
                if (cnt == HALF_LAST) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        state_n = IDLE;
                    end else begin
                        state_n = DATA;
                        bit_n   = '0;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_n   = '0;
                    shreg_n = {rx_s, shreg[DATA_BITS-1:1]};
                    bit_n   = bit_idx + 1'b1;
                    if (bit_idx == BIT_LAST) begin
                        state_n = STOP;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            STOP: begin
                // Return to IDLE mid stop bit so the next start edge
                // is caught even with no idle gap.
                if (cnt == CNT_LAST) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        deliver = 1'b1;
                        state_n = IDLE;
                    end else begin
                        ferr_set = 1'b1;
                        state_n  = BREAK;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            BREAK: begin
                if (rx_s) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            urx_valid     <= 1'b0;
            urx_data      <= '0;
            urx_frame_err <= 1'b0;
            urx_overrun   <= 1'b0;
        end else begin
            urx_frame_err <= ferr_set;
            urx_overrun   <= 1'b0;
            if (deliver) begin
                // A byte leaving this cycle frees the slot.
                if (!urx_valid || urx_ready) begin
                    urx_data  <= shreg;
                    urx_valid <= 1'b1;
                end else begin
                    urx_overrun <= 1'b1;
                end
            end else if (urx_valid && urx_ready) begin
                urx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 10 clocks per bit.
// Scoreboard of expected bytes, popped on each accepted handshake.
module tb_uart_rx;

    localparam int CF  = 1_000_000;
    localparam int BR  = 100_000;
    localparam int CPB = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       urx_pin;
    logic       urx_valid;
    logic [7:0] urx_data;
    logic       urx_ready;
    logic       urx_frame_err;
    logic       urx_overrun;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int vcyc   = 0;
    int start_cyc = 0;
    int first_v_cyc = -1;
    logic prev_v = 1'b0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    uart_rx #(
        .CLOCK_FREQ(CF),
        .BAUD_RATE (BR)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .urx_pin      (urx_pin),
        .urx_valid    (urx_valid),
        .urx_data     (urx_data),
        .urx_ready    (urx_ready),
        .urx_frame_err(urx_frame_err),
        .urx_overrun  (urx_overrun)
    );

    task automatic check(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (urx_frame_err) fe_cnt++;
            if (urx_overrun) ov_cnt++;
            if (urx_frame_err | urx_overrun)
                check("excl", 32'(urx_frame_err & urx_overrun), 0);
            if (urx_valid) begin
                vcyc++;
                if (!prev_v && first_v_cyc < 0)
                    first_v_cyc = cyc;
            end
            if (urx_valid && urx_ready) begin
                if (exp_q.size() == 0)
                    check("unexp", exp_q.size(), 1);
                else
                    check("data", urx_data, exp_q.pop_front());
            end else if (urx_valid && exp_q.size() > 0) begin
                check("hold", urx_data, exp_q[0]);
            end
            prev_v = urx_valid;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(
        input logic [7:0] b,
        input logic       stop_b,
        input int         rst_bit
    );
        urx_pin   = 1'b0;
        start_cyc = cyc;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            urx_pin = b[i];
            if (i == rst_bit) begin
                tick(5);
                rst = 1'b1;
                tick(1);
                check("rst_valid", urx_valid, 0);
                check("rst_data", urx_data, 0);
                check("rst_ferr", urx_frame_err, 0);
                check("rst_ovr", urx_overrun, 0);
                rst = 1'b0;
                tick(4);
            end else begin
                tick(CPB);
            end
        end
        urx_pin = stop_b;
        tick(CPB);
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && exp_q.size() > 0; i++)
            tick(1);
        check("drain", exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0, f0, o0, lat;
        rst       = 1'b1;
        urx_pin   = 1'b1;
        urx_ready = 1'b0;
        tick(3);
        check("reset_valid", urx_valid, 0);
        check("reset_data", urx_data, 0);
        check("reset_ferr", urx_frame_err, 0);
        check("reset_ovr", urx_overrun, 0);
        rst = 1'b0;
        tick(5);

        // single byte, latency
        urx_ready   = 1'b1;
        first_v_cyc = -1;
        v0 = vcyc; f0 = fe_cnt; o0 = ov_cnt;
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1, -1);
        tick(20);
        drain();
        lat = first_v_cyc - start_cyc;
        check("s1_vcyc", vcyc - v0, 1);
        check("s1_lat_ok", 32'(lat >= 97 && lat <= 99), 1);
        check("s1_ferr", fe_cnt - f0, 0);
        check("s1_ovr", ov_cnt - o0, 0);

        // overrun
        urx_ready = 1'b0;
        o0 = ov_cnt; f0 = fe_cnt;
        exp_q.push_back(8'hA3);
        send_frame(8'hA3, 1'b1, -1);
        send_frame(8'h3C, 1'b1, -1);
        tick(20);
        check("s2_ovr", ov_cnt - o0, 1);
        check("s2_ferr", fe_cnt - f0, 0);
        check("s2_valid", urx_valid, 1);
        check("s2_data", urx_data, 8'hA3);
        urx_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("s2_clr", urx_valid, 0);
        check("s2_q", exp_q.size(), 0);
        tick(5);

        // framing error + break
        v0 = vcyc; f0 = fe_cnt;
        send_frame(8'h00, 1'b0, -1);
        urx_pin = 1'b0;
        tick(30 * CPB);
        urx_pin = 1'b1;
        tick(2 * CPB);
        check("s3_ferr", fe_cnt - f0, 1);
        check("s3_vcyc", vcyc - v0, 0);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1, -1);
        tick(20);
        drain();

        // glitch rejection
        v0 = vcyc; f0 = fe_cnt; o0 = ov_cnt;
        urx_pin = 1'b0;
        tick(3);
        urx_pin = 1'b1;
        tick(30);
        check("s4_vcyc", vcyc - v0, 0);
        check("s4_ferr", fe_cnt - f0, 0);
        check("s4_ovr", ov_cnt - o0, 0);
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b1, -1);
        tick(20);
        drain();

        // reset mid-frame
        v0 = vcyc; f0 = fe_cnt; o0 = ov_cnt;
        send_frame(8'hF0, 1'b1, 4);
        tick(20);
        check("s5_vcyc", vcyc - v0, 0);
        check("s5_ferr", fe_cnt - f0, 0);
        check("s5_ovr", ov_cnt - o0, 0);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, -1);
        tick(20);
        drain();

        // back-to-back stream
        v0 = vcyc; f0 = fe_cnt; o0 = ov_cnt;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h01);
        send_frame(8'h00, 1'b1, -1);
        send_frame(8'hFF, 1'b1, -1);
        send_frame(8'h01, 1'b1, -1);
        tick(20);
        drain();
        check("s6_vcyc", vcyc - v0, 3);
        check("s6_ferr", fe_cnt - f0, 0);
        check("s6_ovr", ov_cnt - o0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver: stage directly upstream of the demo's byte-consuming logic.
- Converts the asynchronous `urx_pin` serial line (8N1, LSB first) into bytes on a valid/ready handshake.
- One clock domain, single-entry output buffer.
- Reports framing errors and overruns as single-cycle pulses.

Parameters:
- CLOCK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD_RATE, 115_200, serial bit rate in Hz.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- urx_pin  input  1  asynchronous serial line; idles high.
- urx_valid  output  1  byte available on urx_data.
- urx_data  output  8  received byte; stable while urx_valid=1.
- urx_ready  input  1  consumer accepts the byte when urx_valid && urx_ready.
- urx_frame_err  output  1  1-cycle pulse: stop bit sampled 0.
- urx_overrun  output  1  1-cycle pulse: completed byte dropped because the buffer was full.

Behaviour:
- Constants:
  - CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE (integer floor); must be >= 4.
  - HALF_BIT = CLKS_PER_BIT / 2.
  - Counter width = $clog2(CLKS_PER_BIT).
- Input synchronizer: 2 flops; both reset to 1. All FSM decisions use the second flop (`rx_s`).
- Reset values: urx_valid=0, urx_data=0, urx_frame_err=0, urx_overrun=0, FSM=IDLE, counters=0. Reset mid-frame abandons the frame with no pulses; the next falling edge starts a fresh frame.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: rx_s==0 -> START, bit counter cleared.
  - START: count HALF_BIT cycles, then sample rx_s.
    - 1 -> IDLE (glitch rejected, no pulses).
    - 0 -> DATA; bit index=0, counter cleared.
  - DATA: every CLKS_PER_BIT cycles, sample rx_s into the shift register (LSB first). After the 8th sample -> STOP.
  - STOP: after CLKS_PER_BIT cycles, sample rx_s.
    - 1 -> deliver byte, go to IDLE. Receiver is re-armed mid-stop-bit, so back-to-back frames are tolerated.
    - 0 -> urx_frame_err=1 for one cycle, byte discarded, go to BREAK.
  - BREAK: wait until rx_s==1, then -> IDLE. A held-low line (break) yields exactly one frame_err and no further frames.
- Delivery, in the cycle after the stop sample:
  - Buffer empty, or urx_valid && urx_ready in that same cycle: load urx_data, set urx_valid=1. No overrun.
  - urx_valid=1 && urx_ready=0: keep the old byte, pulse urx_overrun for one cycle, drop the new byte.
- Handshake:
  - urx_valid stays high, with urx_data unchanged, until urx_valid && urx_ready.
  - On acceptance, urx_valid clears the next cycle unless a new byte loads in that same cycle.
  - urx_ready is ignored while urx_valid=0; no combinational path from urx_ready to any output.
- Latency: pin falling edge to urx_valid rising = 2 (sync) + HALF_BIT + 9*CLKS_PER_BIT + 1 cycles, ±1.
- urx_frame_err and urx_overrun never assert in the same cycle as each other.

Decomposition:
- Package `uart_pkg`:
  - FSM state enum: IDLE, START, DATA, STOP, BREAK.
  - Function computing CLKS_PER_BIT from CLOCK_FREQ and BAUD_RATE; shared with the future uart_tx.
  - Constant DATA_BITS=8.
- Sub-module `uart_rx_sync`: 2-flop synchronizer with a reset-value parameter (here 1). Reused by other asynchronous inputs.
- uart_rx contains the FSM, counters, shift register and output buffer.

Test Plan:
- All scenarios run with CLOCK_FREQ=1_000_000 and BAUD_RATE=100_000, so CLKS_PER_BIT=10 and HALF_BIT=5.
- Scenario 1, single byte: urx_ready=1, send frame 0x55 -> exactly one cycle of urx_valid with urx_data=0x55, within ~98 ±1 cycles of the start edge. No error pulses.
- Scenario 2, overrun: urx_ready=0, send 0xA3 then 0x3C back-to-back -> urx_valid=1 with data 0xA3 throughout. One urx_overrun pulse after the 0x3C stop bit. Raising urx_ready then yields 0xA3 once and urx_valid=0 the following cycle.
- Scenario 3, framing error and break:
  - Send 0x00 with stop bit 0, then hold the line low 30 bit-times -> exactly one urx_frame_err pulse, no urx_valid.
  - Release the line, then send 0x81 -> urx_data=0x81 is delivered.
- Scenario 4, glitch rejection: pulse urx_pin low for 3 cycles -> FSM returns to IDLE, no valid, no error pulses. A following 0x7E is received correctly.
- Scenario 5, reset mid-frame: assert rst for 1 cycle during DATA bit 4 of 0xF0 -> all outputs 0 the next cycle, no pulses. A following full frame 0x5A is received as 0x5A.
- Scenario 6, back-to-back streaming: urx_ready=1, send 0x00, 0xFF, 0x01 with no idle gap -> three valid pulses carrying 0x00, 0xFF, 0x01 in order. No overrun, no frame_err.
